// File: rtl/dac_serial_tx_pkg.sv
// dac_tx_pkg: shared FSM encoding and counter sizing for the DAC serial transmitter
package dac_tx_pkg;
  typedef enum logic [2:0] {IDLE, READ, LOAD, SHIFT, SYNC_HI, LDAC} state_t;
  localparam int UNDERRUN_CNT_W = 16;
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/dac_serial_tx_if.sv
// dac_serial_tx_if: FIFO read side plus DAC serial pins and status of the transmitter
interface dac_serial_tx_if #(parameter int pDAC_DW = 24);
  import dac_tx_pkg::*;
  logic                      fifo_empty;
  logic                      fifo_read;
  logic [pDAC_DW-1:0]        fifo_read_data;
  logic                      dac_sync_n;
  logic                      dac_sclk;
  logic                      dac_sdi;
  logic                      dac_ldac_n;
  logic                      busy;
  logic [UNDERRUN_CNT_W-1:0] underrun_cnt;
  logic                      overrun;
  modport slave (
    input  fifo_empty, fifo_read_data,
    output fifo_read, dac_sync_n, dac_sclk, dac_sdi, dac_ldac_n, busy, underrun_cnt, overrun
  );
  modport master (
    output fifo_empty, fifo_read_data,
    input  fifo_read, dac_sync_n, dac_sclk, dac_sdi, dac_ldac_n, busy, underrun_cnt, overrun
  );
endinterface

// File: rtl/dac_serial_tx_tick_gen.sv
// dac_tx_tick_gen: sample-period down-counter emitting a one-cycle tick while enabled
module dac_tx_tick_gen import dac_tx_pkg::*; #(
  parameter int pSAMPLE_PERIOD = 128
) (
  input  logic iclk,
  input  logic irst,
  input  logic ien,
  output logic o_tick
);
  localparam int TICK_W = cnt_w(pSAMPLE_PERIOD);
  localparam logic [TICK_W-1:0] RELOAD = TICK_W'(pSAMPLE_PERIOD - 1);
  logic [TICK_W-1:0] r_cnt;
  assign o_tick = ien && (r_cnt == '0);
  // count down to zero and reload; parked at the reload value while disabled
  always_ff @(posedge iclk or posedge irst)
    if (irst) r_cnt <= RELOAD;
    else r_cnt <= (!ien || r_cnt == '0) ? RELOAD : r_cnt - 1'b1;
endmodule

// File: rtl/dac_serial_tx.sv
// dac_serial_tx: pops one FIFO sample per tick and shifts it MSB-first to an SPI-style DAC
module dac_serial_tx import dac_tx_pkg::*; #(
  parameter int                 pDAC_DW        = 24,
  parameter int                 pCLK_DIV       = 2,
  parameter int                 pSAMPLE_PERIOD = 128,
  parameter logic [pDAC_DW-1:0] pIDLE_CODE     = '0
) (
  input logic iclk,
  input logic irst,
  input logic ien,
  dac_serial_tx_if.slave bus
);
  localparam int DIV_W = cnt_w(2 * pCLK_DIV);
  localparam int BIT_W = cnt_w(pDAC_DW);
  localparam logic [DIV_W-1:0] HALF     = DIV_W'(pCLK_DIV);
  localparam logic [DIV_W-1:0] LAST_PH  = DIV_W'(2 * pCLK_DIV - 1);
  localparam logic [DIV_W-1:0] HOLD_END = DIV_W'(pCLK_DIV - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(pDAC_DW - 1);
  state_t                    r_state, w_next;
  logic                      w_tick, w_ph_end, r_udr, r_ovr;
  logic [DIV_W-1:0]          r_ph;
  logic [BIT_W-1:0]          r_bit;
  logic [pDAC_DW-1:0]        r_sh, r_last;
  logic [UNDERRUN_CNT_W-1:0] r_udr_cnt;
  dac_tx_tick_gen #(.pSAMPLE_PERIOD(pSAMPLE_PERIOD)) u_tick (
    .iclk(iclk), .irst(irst), .ien(ien), .o_tick(w_tick)
  );
  assign w_ph_end = (r_state == SHIFT) ? (r_ph == LAST_PH) : (r_ph == HOLD_END);
  // frame sequencing and pin decode; pins are pure functions of registered state so reset clears them at once
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    w_next = w_tick ? READ : IDLE;
      READ:    w_next = LOAD;
      LOAD:    w_next = SHIFT;
      SHIFT:   w_next = (w_ph_end && r_bit == LAST_BIT) ? SYNC_HI : SHIFT;
      SYNC_HI: w_next = w_ph_end ? LDAC : SYNC_HI;
      LDAC:    w_next = w_ph_end ? IDLE : LDAC;
      default: w_next = IDLE;
    endcase
    bus.fifo_read    = (r_state == READ) && !r_udr;
    bus.dac_sync_n   = r_state != SHIFT;
    bus.dac_sclk     = !(r_state == SHIFT && r_ph >= HALF);
    bus.dac_sdi      = (r_state == SHIFT) && r_sh[pDAC_DW-1];
    bus.dac_ldac_n   = r_state != LDAC;
    bus.busy         = r_state != IDLE;
    bus.underrun_cnt = r_udr_cnt;
    bus.overrun      = r_ovr;
  end
  // state, SCLK phase, bit count and sample registers; phase restarts on every state change
  always_ff @(posedge iclk or posedge irst)
    if (irst) begin
      r_state <= IDLE;
      r_udr   <= 1'b0;
      r_ph    <= '0;
      r_bit   <= '0;
      r_sh    <= '0;
      r_last  <= pIDLE_CODE;
    end else begin
      r_state <= w_next;
      r_ph    <= (w_next != r_state || w_ph_end) ? '0 : r_ph + 1'b1;
      if (r_state == IDLE && w_tick) r_udr <= bus.fifo_empty;
      if (r_state == LOAD) begin
        r_sh  <= r_udr ? r_last : bus.fifo_read_data;
        r_bit <= '0;
      end else if (r_state == SHIFT && w_ph_end) begin
        r_sh  <= r_sh << 1;
        r_bit <= r_bit + 1'b1;
      end
      if (r_state == LOAD && !r_udr) r_last <= bus.fifo_read_data;
    end
  // saturating underrun count and sticky overrun for ticks that land mid-frame
  always_ff @(posedge iclk or posedge irst)
    if (irst) begin
      r_udr_cnt <= '0;
      r_ovr     <= 1'b0;
    end else begin
      if (w_tick && r_state == IDLE && bus.fifo_empty && r_udr_cnt != '1) r_udr_cnt <= r_udr_cnt + 1'b1;
      if (w_tick && r_state != IDLE) r_ovr <= 1'b1;
    end
endmodule
